nanov_spi_fetch: RTL and testbench

NANOV_SPI_FETCH -- requirements
Module: nanov_spi_fetch

---
 rtl/nanov_spi_fetch_if.sv | 24 ++
 rtl/nanov_spi_fetch.sv | 159 +++++++++++++++
 tb/tb_nanov_spi_fetch.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nanov_spi_fetch_if.sv
// Core-side fetch handshake and SPI flash pins of the nanov instruction fetcher.
// The fetcher drives through the master modport; core/flash models use slave.
interface nanov_spi_fetch_if;
    logic        branch;
    logic [23:0] branch_addr;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [23:0] pc;
    logic        spi_cs_n;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;

    modport master (
        input  branch, branch_addr, instr_ready, spi_miso,
        output instr_valid, instr, pc, spi_cs_n, spi_clk, spi_mosi
    );

    modport slave (
        output branch, branch_addr, instr_ready, spi_miso,
        input  instr_valid, instr, pc, spi_cs_n, spi_clk, spi_mosi
    );
endinterface

// File: rtl/nanov_spi_fetch.sv
// Streams 32-bit instruction words from SPI flash (READ 0x03) into a
// one-deep output register, with branch restart and back-pressure stall.
//
// state   | meaning
// --------+-----------------------------------------------------------
// CS_HIGH | chip select released for one cycle before a new command
// CMD     | shifting out the 8-bit READ opcode
// ADDR    | shifting out the 24-bit fetch address
// DATA    | receiving 32 bits per word, continuous across words
// STALL   | full word held in the shift register, output still occupied
module nanov_spi_fetch #(
    parameter logic [23:0] RESET_ADDR = 24'h000000
) (
    input  logic              clk,
    input  logic              rstn,
    nanov_spi_fetch_if.master bus
);
    typedef enum logic [2:0] {CS_HIGH, CMD, ADDR, DATA, STALL} state_t;

    localparam logic [31:0] CMD_READ        = 32'h0000_0003;
    localparam logic [23:0] RESET_WORD_ADDR = {RESET_ADDR[23:2], 2'b00};

    state_t      state_q, state_d;
    logic        phase_q;
    logic [4:0]  bit_cnt_q;
    logic [31:0] shreg_q;
    logic [23:0] fetch_addr_q;
    logic [31:0] instr_q;
    logic [23:0] pc_q;
    logic        valid_q;

    logic        bit_end;
    logic        spi_active;
    logic        cnt_load;
    logic [4:0]  cnt_val;
    logic        load_out;
    logic        mosi;
    logic [31:0] shreg_in;
    logic [31:0] word_raw;
    logic [31:0] addr_bits;
    logic [23:0] branch_word_addr;

    assign bit_end          = phase_q && (bit_cnt_q == 5'd0);
    assign shreg_in         = {shreg_q[30:0], bus.spi_miso};
    assign addr_bits        = {8'h00, fetch_addr_q};
    assign branch_word_addr = bus.branch_addr & 24'hFF_FFFC;

    always_comb begin
        state_d    = state_q;
        spi_active = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = 5'd0;
        load_out   = 1'b0;
        mosi       = 1'b0;
        word_raw   = shreg_in;
        case (state_q)
            CS_HIGH: begin
                state_d  = CMD;
                cnt_load = 1'b1;
                cnt_val  = 5'd7;
            end
            CMD: begin
                spi_active = 1'b1;
                mosi       = CMD_READ[bit_cnt_q];
                if (bit_end) begin
                    state_d  = ADDR;
                    cnt_load = 1'b1;
                    cnt_val  = 5'd23;
                end
            end
            ADDR: begin
                spi_active = 1'b1;
                mosi       = addr_bits[bit_cnt_q];
                if (bit_end) begin
                    state_d  = DATA;
                    cnt_load = 1'b1;
                    cnt_val  = 5'd31;
                end
            end
            DATA: begin
                spi_active = 1'b1;
                if (bit_end) begin
                    if (!valid_q || bus.instr_ready) begin
                        load_out = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = 5'd31;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                // the completed word was captured into shreg_q on entry
                word_raw = shreg_q;
                if (bus.instr_ready) begin
                    load_out = 1'b1;
                    state_d  = DATA;
                    cnt_load = 1'b1;
                    cnt_val  = 5'd31;
                end
            end
            default: state_d = CS_HIGH;
        endcase
        if (bus.branch) begin
            state_d  = CS_HIGH;
            load_out = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= CS_HIGH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q      <= 1'b0;
            bit_cnt_q    <= 5'd0;
            shreg_q      <= 32'd0;
            fetch_addr_q <= RESET_WORD_ADDR;
            instr_q      <= 32'd0;
            pc_q         <= 24'd0;
            valid_q      <= 1'b0;
        end else if (bus.branch) begin
            phase_q      <= 1'b0;
            shreg_q      <= 32'd0;
            fetch_addr_q <= branch_word_addr;
            valid_q      <= 1'b0;
        end else begin
            if (cnt_load) begin
                phase_q   <= 1'b0;
                bit_cnt_q <= cnt_val;
            end else if (spi_active) begin
                phase_q <= ~phase_q;
                if (phase_q) bit_cnt_q <= bit_cnt_q - 5'd1;
            end
            if (state_q == DATA && phase_q) shreg_q <= shreg_in;
            // bytes arrive b0 first, so the shifted word is byte-reversed
            if (load_out) begin
                instr_q      <= {word_raw[7:0], word_raw[15:8], word_raw[23:16], word_raw[31:24]};
                pc_q         <= fetch_addr_q;
                valid_q      <= 1'b1;
                fetch_addr_q <= fetch_addr_q + 24'd4;
            end else if (bus.instr_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.spi_cs_n    = (state_q == CS_HIGH);
    assign bus.spi_clk     = spi_active & phase_q;
    assign bus.spi_mosi    = mosi;
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = valid_q;
endmodule

// File: tb/tb_nanov_spi_fetch.sv
// Bench for nanov_spi_fetch: SPI flash models, queue scoreboard on the
// instr handshake, a branch vector table and hand-written corner sequences.
`timescale 1ns/1ps
module tb_nanov_spi_fetch;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rstn1 = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nanov_spi_fetch_if b0 ();
    nanov_spi_fetch_if b1 ();

    nanov_spi_fetch #(.RESET_ADDR(24'h000000)) dut0 (.clk(clk), .rstn(rstn),  .bus(b0));
    nanov_spi_fetch #(.RESET_ADDR(24'hFFFFF8)) dut1 (.clk(clk), .rstn(rstn1), .bus(b1));

    function automatic logic [7:0] byte_at(input logic [23:0] a);
        logic [31:0] w0;
        w0 = 32'h0000_0513;
        if (a < 24'd4) return w0[8*a[1:0] +: 8];
        return a[7:0] ^ {a[13:8], 2'b01} ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] a);
        return {byte_at(a + 24'd3), byte_at(a + 24'd2), byte_at(a + 24'd1), byte_at(a)};
    endfunction

    // flash models: capture opcode+address, then stream bytes from byte_at
    logic [1:0] f_sclk, f_cs_n, f_mosi;
    assign f_sclk = {b1.spi_clk,  b0.spi_clk};
    assign f_cs_n = {b1.spi_cs_n, b0.spi_cs_n};
    assign f_mosi = {b1.spi_mosi, b0.spi_mosi};

    for (genvar g = 0; g < 2; g++) begin : g_flash
        logic [31:0] hdr = 32'd0;
        int bits = 0;
        int dcnt = 0;
        int sessions = 0;
        logic miso = 1'b0;
        always @(negedge f_cs_n[g]) begin
            hdr = 32'd0;
            bits = 0;
            dcnt = 0;
            sessions++;
        end
        always @(posedge f_sclk[g]) begin
            if (!f_cs_n[g] && bits < 32) begin
                hdr = {hdr[30:0], f_mosi[g]};
                bits++;
            end
        end
        always @(negedge f_sclk[g]) begin
            if (!f_cs_n[g] && bits == 32) begin
                logic [7:0] cur;
                cur  = byte_at(hdr[23:0] + 24'(dcnt / 8));
                miso = cur[7 - (dcnt % 8)];
                dcnt++;
            end
        end
    end
    assign b0.spi_miso = g_flash[0].miso;
    assign b1.spi_miso = g_flash[1].miso;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [23:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sbq[$];

    function automatic void push_words(input logic [23:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc    = a + 24'(4 * i);
            e.instr = word_at(e.pc);
            sbq.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (rstn && b0.instr_valid && b0.instr_ready && !b0.branch && sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_pc", 64'(b0.pc), 64'(e.pc));
            chk("sb_instr", 64'(b0.instr), 64'(e.instr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk(name, 64'(sbq.size()), 64'd0);
    endtask

    task automatic wait_valid(input string name, input int bound);
        int n;
        n = 0;
        while (!b0.instr_valid && n < bound) begin
            tick();
            n++;
        end
        chk(name, 64'(b0.instr_valid), 64'd1);
    endtask

    task automatic do_branch(input logic [23:0] a);
        sbq.delete();
        b0.branch_addr = a;
        b0.branch = 1'b1;
        tick();
        b0.branch = 1'b0;
    endtask

    typedef struct {
        logic [23:0] baddr;
        logic [23:0] exp_pc;
        int          hold;
        int          nwords;
        int          pre;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, viol, hold_bad, base, got, n;
        logic [23:0] p;
        logic [23:0] wrap_pcs[3];

        vecs[0] = '{24'h000123, 24'h000120,   0, 2, 20};
        vecs[1] = '{24'h00ABCE, 24'h00ABCC,  90, 2, 47};
        vecs[2] = '{24'hFFFFFC, 24'hFFFFFC,   0, 2, 33};
        vecs[3] = '{24'h400007, 24'h400004, 150, 3, 71};
        wrap_pcs = '{24'hFFFFF8, 24'hFFFFFC, 24'h000000};

        b0.branch = 1'b0; b0.branch_addr = 24'd0; b0.instr_ready = 1'b1;
        b1.branch = 1'b0; b1.branch_addr = 24'd0; b1.instr_ready = 1'b1;

        // reset state and first fetch from address 0
        #3;
        chk("reset_outs", 64'({b0.spi_cs_n, b0.spi_clk, b0.spi_mosi, b0.instr_valid, b0.instr, b0.pc}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 24'd0}));
        base = g_flash[0].sessions;
        push_words(24'd0, 3);
        @(posedge clk); #1;
        rstn = 1'b1;
        cyc = 0;
        while (!b0.instr_valid && cyc < 300) begin
            tick();
            cyc++;
        end
        b0.instr_ready = 1'b0;
        chk("first_valid_cycle", 64'(cyc), 64'd129);
        chk("first_instr", 64'(b0.instr), 64'h0000_0513);
        chk("first_pc", 64'(b0.pc), 64'd0);
        chk("first_hdr", 64'(g_flash[0].hdr), 64'h0300_0000);

        // back-pressure: second word parks in STALL with the SPI clock frozen
        viol = 0;
        hold_bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (i >= 70 && (b0.spi_clk !== 1'b0 || b0.spi_cs_n !== 1'b0)) viol++;
            if (b0.instr !== 32'h0000_0513 || b0.pc !== 24'd0 || b0.instr_valid !== 1'b1) hold_bad++;
        end
        chk("stall_spi_frozen", 64'(viol), 64'd0);
        chk("stall_out_hold", 64'(hold_bad), 64'd0);
        b0.instr_ready = 1'b1;
        tick();
        chk("stall_resume_pc", 64'(b0.pc), 64'd4);
        chk("stall_resume_valid", 64'(b0.instr_valid), 64'd1);
        wait_drain("stall_drain", 200);
        chk("stall_no_recmd", 64'(g_flash[0].sessions - base), 64'd1);

        // branch vector table
        for (int v = 0; v < 4; v++) begin
            repeat (vecs[v].pre) tick();
            base = g_flash[0].sessions;
            do_branch(vecs[v].baddr);
            push_words(vecs[v].exp_pc, vecs[v].nwords);
            chk("vec_valid_cleared", 64'(b0.instr_valid), 64'd0);
            chk("vec_cs_high", 64'(b0.spi_cs_n), 64'd1);
            tick();
            chk("vec_cs_one_cycle", 64'(b0.spi_cs_n), 64'd0);
            wait_valid("vec_first_valid", 300);
            if (vecs[v].hold > 0) begin
                b0.instr_ready = 1'b0;
                repeat (vecs[v].hold) tick();
                b0.instr_ready = 1'b1;
            end
            wait_drain("vec_drain", 400);
            chk("vec_hdr", 64'(g_flash[0].hdr), 64'({8'h03, vecs[v].exp_pc}));
            chk("vec_one_cmd", 64'(g_flash[0].sessions - base), 64'd1);
        end

        // branch landing on the word-completion edge while ready=1
        p = b0.pc;
        n = 0;
        while (b0.pc == p && n < 200) begin
            tick();
            n++;
        end
        chk("coinc_sync", 64'(b0.pc != p), 64'd1);
        repeat (63) tick();
        do_branch(24'h005552);
        push_words(24'h005550, 2);
        chk("coinc_valid_cleared", 64'(b0.instr_valid), 64'd0);
        wait_drain("coinc_drain", 400);

        // second branch arriving during CS_HIGH wins
        do_branch(24'h001000);
        b0.branch_addr = 24'h002006;
        b0.branch = 1'b1;
        push_words(24'h002004, 1);
        tick();
        b0.branch = 1'b0;
        chk("rebranch_cs_high", 64'(b0.spi_cs_n), 64'd1);
        tick();
        chk("rebranch_cs_low", 64'(b0.spi_cs_n), 64'd0);
        wait_drain("rebranch_drain", 400);
        chk("rebranch_hdr", 64'(g_flash[0].hdr), 64'h0300_2004);

        // asynchronous reset in the middle of the address phase
        do_branch(24'h345678);
        repeat (27) tick();
        rstn = 1'b0;
        #2;
        chk("midaddr_reset_outs", 64'({b0.spi_cs_n, b0.spi_clk, b0.spi_mosi, b0.instr_valid, b0.instr, b0.pc}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 24'd0}));
        repeat (3) tick();
        base = g_flash[0].sessions;
        push_words(24'd0, 2);
        rstn = 1'b1;
        wait_drain("postreset_drain", 400);
        chk("postreset_hdr", 64'(g_flash[0].hdr), 64'h0300_0000);
        chk("postreset_one_cmd", 64'(g_flash[0].sessions - base), 64'd1);

        // address wrap on the RESET_ADDR=FFFFF8 instance
        base = g_flash[1].sessions;
        rstn1 = 1'b1;
        got = 0;
        for (int c = 0; c < 600 && got < 3; c++) begin
            @(negedge clk);
            if (b1.instr_valid && b1.instr_ready) begin
                chk("wrap_pc", 64'(b1.pc), 64'(wrap_pcs[got]));
                chk("wrap_instr", 64'(b1.instr), 64'(word_at(wrap_pcs[got])));
                got++;
            end
        end
        chk("wrap_count", 64'(got), 64'd3);
        chk("wrap_hdr", 64'(g_flash[1].hdr), 64'h03FF_FFF8);
        chk("wrap_one_cmd", 64'(g_flash[1].sessions - base), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
